tl_burst_arbiter: RTL and testbench

- Generic N:1 round-robin arbiter for multi-beat TileLink channels (A or C host-side merge, D/B device-side merge).
- Computes burst length internally from size and has-data, so no separate burst tracker is needed.
- Locks the grant from the first presented beat through the last beat of the message.
- Instantiated by N:1 sockets, one instance per merged channel.

---
 rtl/tl_burst_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_tl_burst_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tl_burst_arbiter.sv
// N:1 round-robin arbiter for multi-beat TileLink channels.
// The grant is locked from the first presented beat of a message until its
// last beat is accepted; burst length is derived from size and has-data.
module tl_burst_arbiter #(
  parameter int NumReq       = 2,
  parameter int DataWidth    = 64,
  parameter int SizeWidth    = 3,
  parameter int MaxSize      = 6,
  parameter int PayloadWidth = 64,
  localparam int OffW        = $clog2(DataWidth / 8),
  localparam int BeatW       = ((MaxSize - OffW) > 1) ? (MaxSize - OffW) : 1,
  localparam int PtrW        = (NumReq > 1) ? $clog2(NumReq) : 1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic [NumReq-1:0]                req_valid_i,
  output logic [NumReq-1:0]                req_ready_o,
  input  logic [NumReq*SizeWidth-1:0]      req_size_i,
  input  logic [NumReq-1:0]                req_has_data_i,
  input  logic [NumReq*PayloadWidth-1:0]   req_payload_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [SizeWidth-1:0]             out_size_o,
  output logic [PayloadWidth-1:0]          out_payload_o,
  output logic [NumReq-1:0]                out_grant_o,
  output logic                             out_first_o,
  output logic                             out_last_o,
  output logic [BeatW-1:0]                 out_beat_idx_o
);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [PtrW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [NumReq-1:0]   sel_q, sel_d;
  logic [BeatW-1:0]    cnt_q, cnt_d;

  logic [SizeWidth-1:0]    size_arr    [NumReq];
  logic [PayloadWidth-1:0] payload_arr [NumReq];

  logic                    pick_found;
  logic [PtrW-1:0]         pick_idx;
  logic [PtrW-1:0]         sel_idx;
  logic [NumReq-1:0]       select;
  logic                    mux_valid;
  logic                    mux_has_data;
  logic [SizeWidth-1:0]    mux_size;
  logic [PayloadWidth-1:0] mux_payload;
  logic [BeatW-1:0]        last_cnt;
  logic                    handshake;

  // Wrap-around increment of a requester index.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    int n;
    n = int'(p) + 1;
    if (n >= NumReq) begin
      n = 0;
    end
    return PtrW'(n);
  endfunction

  // Slice the flattened per-requester fields into arrays.
  generate
    for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
      assign size_arr[gi]    = req_size_i[gi*SizeWidth +: SizeWidth];
      assign payload_arr[gi] = req_payload_i[gi*PayloadWidth +: PayloadWidth];
    end
  endgenerate

  // Round-robin pick: valid requester closest above rr_ptr (inclusive).
  always_comb begin
    int best_pri;
    int pri;
    pick_found = 1'b0;
    pick_idx   = '0;
    best_pri   = NumReq;
    pri        = 0;
    for (int i = 0; i < NumReq; i++) begin
      pri = (i - int'(rr_ptr_q) + NumReq) % NumReq;
      if (req_valid_i[i] && (pri < best_pri)) begin
        best_pri   = pri;
        pick_found = 1'b1;
        pick_idx   = PtrW'(i);
      end
    end
  end

  // Binary index of the locked selection, used to advance rr_ptr.
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (sel_q[i]) begin
        sel_idx = PtrW'(i);
      end
    end
  end

  // Current one-hot selection: locked owner, else the round-robin pick.
  always_comb begin
    select = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (state_q == ST_LOCK) begin
        select[i] = sel_q[i];
      end else begin
        select[i] = pick_found && (pick_idx == PtrW'(i));
      end
    end
  end

  // One-hot AND-OR mux of the selected requester's fields.
  always_comb begin
    mux_valid    = 1'b0;
    mux_has_data = 1'b0;
    mux_size     = '0;
    mux_payload  = '0;
    for (int i = 0; i < NumReq; i++) begin
      if (select[i]) begin
        mux_valid    = mux_valid | req_valid_i[i];
        mux_has_data = mux_has_data | req_has_data_i[i];
        mux_size     = mux_size | size_arr[i];
        mux_payload  = mux_payload | payload_arr[i];
      end
    end
  end

  // Index of the final beat of the selected message (beats - 1).
  always_comb begin
    last_cnt = '0;
    if (mux_has_data && (int'(mux_size) > OffW)) begin
      last_cnt = BeatW'((1 << (int'(mux_size) - OffW)) - 1);
    end
  end

  assign handshake      = mux_valid && out_ready_i;
  assign out_valid_o    = mux_valid;
  assign out_size_o     = mux_size;
  assign out_payload_o  = mux_payload;
  assign out_grant_o    = select;
  assign req_ready_o    = select & {NumReq{out_ready_i}};
  assign out_first_o    = (cnt_q == '0);
  assign out_last_o     = (cnt_q == last_cnt);
  assign out_beat_idx_o = cnt_q;

  // Next-state: arbitrate in ARB, hold the owner in LOCK until its last beat.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    case (state_q)
      ST_ARB: begin
        if (pick_found) begin
          if (handshake && (last_cnt == '0)) begin
            // Single-beat message completes without locking.
            rr_ptr_d = ptr_inc(pick_idx);
          end else if (handshake) begin
            state_d = ST_LOCK;
            sel_d   = select;
            cnt_d   = BeatW'(1);
          end else begin
            // Presented but stalled: freeze the choice while valid is high.
            state_d = ST_LOCK;
            sel_d   = select;
          end
        end
      end
      ST_LOCK: begin
        if (handshake) begin
          if (out_last_o) begin
            state_d  = ST_ARB;
            cnt_d    = '0;
            rr_ptr_d = ptr_inc(sel_idx);
            sel_d    = '0;
          end else begin
            cnt_d = cnt_q + BeatW'(1);
          end
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_ARB;
      rr_ptr_q <= '0;
      sel_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
    end
  end

`ifndef SYNTHESIS
  // Flag an illegal message size on a presented beat.
  always @(posedge clk_i) begin
    if (rst_ni && out_valid_o) begin
      assert (int'(out_size_o) <= MaxSize)
        else $error("tl_burst_arbiter: size %0d exceeds MaxSize %0d", out_size_o, MaxSize);
    end
  end
`endif

endmodule

// File: tb/tb_tl_burst_arbiter.sv
// Self-checking bench for tl_burst_arbiter: directed scenarios followed by
// random traffic, all compared against a message-level reference model.
module tb_tl_burst_arbiter;

  localparam int N    = 2;
  localparam int DW   = 64;
  localparam int SW   = 3;
  localparam int MS   = 6;
  localparam int PW   = 64;
  localparam int OFFW = 3;
  localparam int BW   = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*SW-1:0] req_size;
  logic [N-1:0]    req_has_data;
  logic [N*PW-1:0] req_payload;
  logic            out_valid;
  logic            out_ready;
  logic [SW-1:0]   out_size;
  logic [PW-1:0]   out_payload;
  logic [N-1:0]    out_grant;
  logic            out_first;
  logic            out_last;
  logic [BW-1:0]   out_beat_idx;

  always #5 clk = ~clk;

  tl_burst_arbiter #(
    .NumReq(N), .DataWidth(DW), .SizeWidth(SW), .MaxSize(MS), .PayloadWidth(PW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_size_i(req_size), .req_has_data_i(req_has_data),
    .req_payload_i(req_payload),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_size_o(out_size), .out_payload_o(out_payload),
    .out_grant_o(out_grant), .out_first_o(out_first),
    .out_last_o(out_last), .out_beat_idx_o(out_beat_idx)
  );

  // Requester-side stimulus state.
  logic          v  [N];
  int            sz [N];
  logic          hd [N];
  logic [PW-1:0] pl [N];
  int            left [N];

  // Reference model: current message owner (-1 = none), beat within it,
  // and the requester that has first claim at the next arbitration.
  int m_owner, m_beat, m_rr;
  int hs_g;

  logic [N-1:0]  obs_grant;
  logic [BW-1:0] obs_idx;
  logic          obs_first, obs_last, obs_valid;
  logic [PW-1:0] obs_payload;
  logic [PW-1:0] saved_pl;

  int n_cmp = 0;
  int n_err = 0;

  function automatic int beats_of(input int s, input logic d);
    if (d && (s > OFFW)) return 1 << (s - OFFW);
    return 1;
  endfunction

  function automatic int pick();
    for (int k = 0; k < N; k++) begin
      int c;
      c = (m_rr + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]            = v[i];
      req_has_data[i]         = hd[i];
      req_size[i*SW +: SW]    = SW'(sz[i]);
      req_payload[i*PW +: PW] = pl[i];
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_beat  = 0;
    m_rr    = 0;
  endtask

  // One clock: drive, compare at the falling edge, advance the model at the rising edge.
  task automatic cycle();
    int g, nb;
    logic ev;
    logic [N-1:0] eg;
    drive();
    @(negedge clk);
    g  = (m_owner >= 0) ? m_owner : pick();
    ev = (g >= 0) ? v[g] : 1'b0;
    eg = '0;
    if (g >= 0) eg[g] = 1'b1;
    nb = (g >= 0) ? beats_of(sz[g], hd[g]) : 1;
    obs_grant   = out_grant;
    obs_idx     = out_beat_idx;
    obs_first   = out_first;
    obs_last    = out_last;
    obs_valid   = out_valid;
    obs_payload = out_payload;
    chk("valid", out_valid, ev);
    chk("grant", out_grant, eg);
    chk("ready", req_ready, out_ready ? eg : '0);
    chk("beat_idx", out_beat_idx, m_beat);
    chk("first", out_first, m_beat == 0);
    if (g >= 0) begin
      chk("size", out_size, sz[g]);
      chk("payload", out_payload, pl[g]);
      chk("last", out_last, m_beat == nb - 1);
    end
    hs_g = -1;
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else if (ev) begin
      if (out_ready) begin
        if (m_beat == nb - 1) begin
          m_owner = -1;
          m_beat  = 0;
          m_rr    = (g + 1) % N;
        end else begin
          m_owner = g;
          m_beat++;
        end
        hs_g = g;
      end else begin
        m_owner = g;
      end
    end
    #1;
    if (hs_g >= 0) pl[hs_g] = {$urandom, $urandom};
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; sz[i] = 0; hd[i] = 1'b0; pl[i] = '0; left[i] = 0;
    end
    model_reset();
    hs_g = -1;

    // Reset then idle.
    cycle();
    cycle();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      cycle();
      chk("idle_valid", obs_valid, 1'b0);
      chk("idle_grant", obs_grant, 2'b00);
    end

    // Single-beat contention: grants alternate.
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; sz[i] = 3; hd[i] = 1'b1; pl[i] = {$urandom, $urandom};
    end
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("alt_grant", obs_grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("alt_first_last", {obs_first, obs_last}, 2'b11);
    end
    v[0] = 1'b0; v[1] = 1'b0;

    // Burst lock: 8 beats from req0, req1 raised mid-burst.
    v[0] = 1'b1; sz[0] = 6; hd[0] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        v[1] = 1'b1; sz[1] = 3; hd[1] = 1'b1;
      end
      cycle();
      chk("burst_grant", obs_grant, 2'b01);
      chk("burst_idx", obs_idx, k);
      chk("burst_last", obs_last, k == 7);
    end
    v[0] = 1'b0;
    cycle();
    chk("no_bubble_grant", obs_grant, 2'b10);
    chk("no_bubble_valid", obs_valid, 1'b1);
    v[1] = 1'b0;

    // Backpressure hold on req1, then req0 arrives.
    v[1] = 1'b1; sz[1] = 3; hd[1] = 1'b1;
    out_ready = 1'b0;
    saved_pl = pl[1];
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_grant", obs_grant, 2'b10);
      chk("bp_payload", obs_payload, saved_pl);
    end
    v[0] = 1'b1; sz[0] = 3; hd[0] = 1'b1;
    out_ready = 1'b1;
    cycle();
    chk("bp_first_accept", obs_grant, 2'b10);
    v[1] = 1'b0;
    cycle();
    chk("bp_then_req0", obs_grant, 2'b01);
    v[0] = 1'b0;

    // Large size without data is a single beat and advances the pointer.
    v[0] = 1'b1; sz[0] = 6; hd[0] = 1'b0;
    cycle();
    chk("nodata_grant", obs_grant, 2'b01);
    chk("nodata_first_last", {obs_first, obs_last}, 2'b11);
    v[0] = 1'b1; sz[0] = 3; hd[0] = 1'b1;
    v[1] = 1'b1; sz[1] = 3; hd[1] = 1'b1;
    cycle();
    chk("rr_advanced", obs_grant, 2'b10);
    v[1] = 1'b0;
    cycle();
    v[0] = 1'b0;

    // Asynchronous reset in the middle of an 8-beat burst.
    v[0] = 1'b1; sz[0] = 6; hd[0] = 1'b1;
    for (int k = 0; k < 4; k++) cycle();
    #2;
    chk("pre_reset_idx", out_beat_idx, 3'd4);
    rst_n = 1'b0;
    #1;
    chk("async_rst_idx", out_beat_idx, 3'd0);
    chk("async_rst_first", out_first, 1'b1);
    chk("async_rst_grant", out_grant, 2'b01);
    model_reset();
    cycle();
    rst_n = 1'b1;
    v[0] = 1'b0;
    v[1] = 1'b1; sz[1] = 6; hd[1] = 1'b1;
    cycle();
    chk("restart_grant", obs_grant, 2'b10);
    chk("restart_idx", obs_idx, 3'd0);
    for (int k = 0; k < 7; k++) cycle();
    v[1] = 1'b0;
    cycle();

    // Random traffic obeying the hold-until-accepted rule.
    for (int t = 0; t < 800; t++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom_range(2) == 0)) begin
          if (left[i] == 0) begin
            sz[i]   = int'($urandom_range(MS));
            hd[i]   = 1'($urandom_range(1));
            left[i] = beats_of(sz[i], hd[i]);
          end
          v[i] = 1'b1;
        end
      end
      out_ready = ($urandom_range(3) != 0);
      cycle();
      if (hs_g >= 0) begin
        left[hs_g]--;
        if ((left[hs_g] == 0) || ($urandom_range(3) == 0)) v[hs_g] = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
